alu_issue_ctrl: RTL and testbench

Multicycle decode/issue controller on the producer side of the ALU. It accepts 32-bit MIPS instruction words over a valid/ready handshake and decodes op/func/shamt. It reads source operands from the register file, builds the immediate and drives the ALU operand/opcode inputs. It then captures the ALU result and writes it back to the destination register. It sits between instruction fetch and the register file/ALU pair.

---
 rtl/alu_issue_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Multicycle decode/issue controller feeding the ALU.
// Decodes MIPS R/I words, drives the ALU, writes the result back.
module alu_issue_ctrl #(
    parameter int ALU_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic [4:0]  rf_raddr1,
    output logic [4:0]  rf_raddr2,
    input  logic [31:0] rf_rdata1,
    input  logic [31:0] rf_rdata2,
    output logic [31:0] alu_reg1,
    output logic [31:0] alu_reg2,
    output logic [5:0]  alu_op,
    output logic [5:0]  alu_func,
    output logic [4:0]  alu_shamt,
    input  logic [31:0] alu_result,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        done,
    output logic        illegal,
    output logic        busy
);

    localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        EXEC,
        WB
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [31:0]   ir;
    logic [CW-1:0] cnt;
    logic [4:0]    dest;

    logic [5:0]    op;
    logic [5:0]    fn;
    logic          is_r;
    logic          legal;
    logic          sext;
    logic [31:0]   imm;
    logic [31:0]   reg2_n;
    logic [5:0]    func_n;
    logic [4:0]    shamt_n;
    logic [4:0]    dest_n;

    assign op = ir[31:26];
    assign fn = ir[5:0];

    // Classify the latched word and pick immediate extension.
    always_comb begin
        is_r  = 1'b0;
        legal = 1'b0;
        sext  = 1'b0;
        case (op)
            6'b000000: begin
                is_r = 1'b1;
                case (fn)
                    6'b100000, 6'b100100, 6'b100101, 6'b100010,
                    6'b000011, 6'b000010, 6'b000000, 6'b101001:
                        legal = 1'b1;
                    default: legal = 1'b0;
                endcase
            end
            6'b001000, 6'b001001, 6'b001010: begin
                legal = 1'b1;
                sext  = 1'b1;
            end
            6'b001100, 6'b001101, 6'b001111: begin
                legal = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

    // Operand and field selection for the DECODE exit edge.
    always_comb begin
        imm     = sext ? {{16{ir[15]}}, ir[15:0]} : {16'h0000, ir[15:0]};
        reg2_n  = is_r ? rf_rdata2 : imm;
        func_n  = is_r ? fn : 6'd0;
        shamt_n = is_r ? ir[10:6] : 5'd0;
        dest_n  = is_r ? ir[15:11] : ir[20:16];
    end

    assign rf_raddr1 = ir[25:21];
    assign rf_raddr2 = ir[20:16];

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and handshake/pulse outputs.
    always_comb begin
        state_n     = state;
        instr_ready = 1'b0;
        illegal     = 1'b0;
        done        = 1'b0;
        rf_we       = 1'b0;
        busy        = 1'b1;
        case (state)
            IDLE: begin
                instr_ready = 1'b1;
                busy        = 1'b0;
                if (instr_valid) begin
                    state_n = DECODE;
                end
            end
            DECODE: begin
                if (legal) begin
                    state_n = EXEC;
                end else begin
                    illegal = 1'b1;
                    state_n = IDLE;
                end
            end
            EXEC: begin
                if (cnt == '0) begin
                    state_n = WB;
                end
            end
            WB: begin
                done    = 1'b1;
                rf_we   = (rf_waddr != 5'd0);
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Instruction, ALU-facing and write-back registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir        <= '0;
            cnt       <= '0;
            dest      <= '0;
            alu_reg1  <= '0;
            alu_reg2  <= '0;
            alu_op    <= '0;
            alu_func  <= '0;
            alu_shamt <= '0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        ir <= instr;
                    end
                end
                DECODE: begin
                    if (legal) begin
                        alu_reg1  <= rf_rdata1;
                        alu_reg2  <= reg2_n;
                        alu_op    <= op;
                        alu_func  <= func_n;
                        alu_shamt <= shamt_n;
                        dest      <= dest_n;
                        cnt       <= CW'(ALU_LAT - 1);
                    end
                end
                EXEC: begin
                    if (cnt == '0) begin
                        rf_wdata <= alu_result;
                        rf_waddr <= dest;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: two instances (ALU_LAT 1 and 3),
// a register-file/ALU environment and a write-back scoreboard.
module tb_alu_issue_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        we;
        int          cy;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    logic [31:0] regs [32];

    function automatic logic [31:0] alu_f(
        input logic [5:0] op, input logic [5:0] fn,
        input logic [4:0] sh, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        r = '0;
        case (op)
            6'b000000: begin
                case (fn)
                    6'b100000: r = a + b;
                    6'b100100: r = a & b;
                    6'b100101: r = a | b;
                    6'b100010: r = a - b;
                    6'b000011: r = $signed(b) >>> sh;
                    6'b000010: r = b >> sh;
                    6'b000000: r = b << sh;
                    6'b101001: r = {31'b0, a < b};
                    default:   r = '0;
                endcase
            end
            6'b001000, 6'b001001: r = a + b;
            6'b001100: r = a & b;
            6'b001101: r = a | b;
            6'b001010: r = {31'b0, $signed(a) < $signed(b)};
            6'b001111: r = b << 16;
            default:   r = '0;
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- instance A: ALU_LAT=1 ----------------
    logic        a_reset, a_valid, a_ready;
    logic [31:0] a_instr;
    logic [4:0]  a_ra1, a_ra2, a_shamt, a_waddr;
    logic [31:0] a_rd1, a_rd2, a_r1, a_r2, a_res, a_wdata;
    logic [5:0]  a_op, a_func;
    logic        a_we, a_done, a_ill, a_busy;

    assign a_rd1 = regs[a_ra1];
    assign a_rd2 = regs[a_ra2];
    assign a_res = alu_f(a_op, a_func, a_shamt, a_r1, a_r2);

    alu_issue_ctrl #(.ALU_LAT(1)) dut_a (
        .clk(clk), .reset(a_reset),
        .instr_valid(a_valid), .instr_ready(a_ready), .instr(a_instr),
        .rf_raddr1(a_ra1), .rf_raddr2(a_ra2),
        .rf_rdata1(a_rd1), .rf_rdata2(a_rd2),
        .alu_reg1(a_r1), .alu_reg2(a_r2), .alu_op(a_op),
        .alu_func(a_func), .alu_shamt(a_shamt), .alu_result(a_res),
        .rf_we(a_we), .rf_waddr(a_waddr), .rf_wdata(a_wdata),
        .done(a_done), .illegal(a_ill), .busy(a_busy)
    );

    // ---------------- instance B: ALU_LAT=3 ----------------
    logic        b_reset, b_valid, b_ready;
    logic [31:0] b_instr;
    logic [4:0]  b_ra1, b_ra2, b_shamt, b_waddr;
    logic [31:0] b_rd1, b_rd2, b_r1, b_r2, b_res, b_wdata;
    logic [5:0]  b_op, b_func;
    logic        b_we, b_done, b_ill, b_busy;

    assign b_rd1 = regs[b_ra1];
    assign b_rd2 = regs[b_ra2];
    assign b_res = alu_f(b_op, b_func, b_shamt, b_r1, b_r2);

    alu_issue_ctrl #(.ALU_LAT(3)) dut_b (
        .clk(clk), .reset(b_reset),
        .instr_valid(b_valid), .instr_ready(b_ready), .instr(b_instr),
        .rf_raddr1(b_ra1), .rf_raddr2(b_ra2),
        .rf_rdata1(b_rd1), .rf_rdata2(b_rd2),
        .alu_reg1(b_r1), .alu_reg2(b_r2), .alu_op(b_op),
        .alu_func(b_func), .alu_shamt(b_shamt), .alu_result(b_res),
        .rf_we(b_we), .rf_waddr(b_waddr), .rf_wdata(b_wdata),
        .done(b_done), .illegal(b_ill), .busy(b_busy)
    );

    // Scoreboard: retire-side comparison (cycle k ends at edge k).
    always @(negedge clk) begin
        if (a_we) chk("a_we_needs_done", {31'b0, a_done}, 32'd1);
        if (a_done) begin
            chk("a_sb_nonempty", {31'b0, qa.size() != 0}, 32'd1);
            if (qa.size() != 0) begin
                exp_t e;
                e = qa.pop_front();
                chk("a_waddr", {27'b0, a_waddr}, {27'b0, e.wa});
                chk("a_wdata", a_wdata, e.wd);
                chk("a_we", {31'b0, a_we}, {31'b0, e.we});
                chk("a_done_cycle", 32'(cyc + 1), 32'(e.cy));
            end
        end
        if (b_we) chk("b_we_needs_done", {31'b0, b_done}, 32'd1);
        if (b_done) begin
            chk("b_sb_nonempty", {31'b0, qb.size() != 0}, 32'd1);
            if (qb.size() != 0) begin
                exp_t e;
                e = qb.pop_front();
                chk("b_waddr", {27'b0, b_waddr}, {27'b0, e.wa});
                chk("b_wdata", b_wdata, e.wd);
                chk("b_we", {31'b0, b_we}, {31'b0, e.we});
                chk("b_done_cycle", 32'(cyc + 1), 32'(e.cy));
            end
        end
    end

    // Called at a negedge; returns accept edge number, ends at next negedge.
    task automatic send_a(input logic [31:0] w, output int t);
        int n = 0;
        while (!a_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("a_ready_timeout", {31'b0, a_ready}, 32'd1);
        a_valid = 1'b1;
        a_instr = w;
        @(posedge clk);
        #1;
        t = cyc;
        a_valid = 1'b0;
        a_instr = 32'hDEADBEEF;
        @(negedge clk);
    endtask

    task automatic send_b(input logic [31:0] w, output int t);
        int n = 0;
        while (!b_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("b_ready_timeout", {31'b0, b_ready}, 32'd1);
        b_valid = 1'b1;
        b_instr = w;
        @(posedge clk);
        #1;
        t = cyc;
        b_valid = 1'b0;
        b_instr = 32'hDEADBEEF;
        @(negedge clk);
    endtask

    task automatic run_a(input logic [31:0] w, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [4:0] wa,
                         input logic [31:0] wd, input logic we);
        int t;
        exp_t e;
        send_a(w, t);
        e.wa = wa;
        e.wd = wd;
        e.we = we;
        e.cy = t + 3;
        qa.push_back(e);
        chk("a_dec_illegal", {31'b0, a_ill}, 32'd0);
        chk("a_dec_ready", {31'b0, a_ready}, 32'd0);
        chk("a_raddr1", {27'b0, a_ra1}, {27'b0, w[25:21]});
        chk("a_raddr2", {27'b0, a_ra2}, {27'b0, w[20:16]});
        @(negedge clk);
        chk("a_alu_op", {26'b0, a_op}, {26'b0, w[31:26]});
        chk("a_alu_reg1", a_r1, r1);
        chk("a_alu_reg2", a_r2, r2);
        chk("a_alu_func", {26'b0, a_func},
            (w[31:26] == 6'd0) ? {26'b0, w[5:0]} : 32'd0);
        chk("a_alu_shamt", {27'b0, a_shamt},
            (w[31:26] == 6'd0) ? {27'b0, w[10:6]} : 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("a_ready_again", {31'b0, a_ready}, 32'd1);
    endtask

    logic [31:0] bw [3];
    logic [31:0] bres [3];
    logic [4:0]  bdst [3];

    initial begin
        int t;
        int tprev;
        exp_t e;
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        regs[1] = 32'h0000_0100;
        regs[2] = 32'd5;
        regs[4] = 32'd10;
        regs[7] = 32'h8000_0000;

        a_reset = 1'b1; a_valid = 1'b0; a_instr = '0;
        b_reset = 1'b1; b_valid = 1'b0; b_instr = '0;
        #3;
        chk("rst_ready", {31'b0, a_ready}, 32'd1);
        chk("rst_busy", {31'b0, a_busy}, 32'd0);
        chk("rst_done", {31'b0, a_done}, 32'd0);
        chk("rst_we", {31'b0, a_we}, 32'd0);
        chk("rst_alu_reg2", a_r2, 32'd0);
        chk("rst_wdata", a_wdata, 32'd0);
        @(negedge clk);
        a_reset = 1'b0;
        b_reset = 1'b0;
        @(negedge clk);

        // addi $5,$4,-3
        run_a({6'b001000, 5'd4, 5'd5, 16'hFFFD},
              32'd10, 32'hFFFF_FFFD, 5'd5, 32'd7, 1'b1);
        // ori $2,$1,0x8001
        run_a({6'b001101, 5'd1, 5'd2, 16'h8001},
              32'h100, 32'h0000_8001, 5'd2, 32'h0000_8101, 1'b1);
        // lui $3,0xABCD
        run_a({6'b001111, 5'd0, 5'd3, 16'hABCD},
              32'd0, 32'h0000_ABCD, 5'd3, 32'hABCD_0000, 1'b1);
        // sra $6,$7,4
        run_a({6'b000000, 5'd0, 5'd7, 5'd6, 5'd4, 6'b000011},
              32'd0, 32'h8000_0000, 5'd6, 32'hF800_0000, 1'b1);
        // add $0,$1,$2 : retires without a write
        run_a({6'b000000, 5'd1, 5'd2, 5'd0, 5'd0, 6'b100000},
              32'h100, 32'd5, 5'd0, 32'h105, 1'b0);

        // illegal op 111111
        send_a({6'b111111, 26'h0}, t);
        chk("ill_pulse", {31'b0, a_ill}, 32'd1);
        chk("ill_no_done", {31'b0, a_done}, 32'd0);
        chk("ill_alu_func_held", {26'b0, a_func}, 32'h20);
        @(negedge clk);
        chk("ill_ready_t2", {31'b0, a_ready}, 32'd1);
        chk("ill_pulse_end", {31'b0, a_ill}, 32'd0);

        // Back-to-back with instr_valid held high.
        bw[0] = {6'b001000, 5'd4, 5'd8, 16'h0001};
        bw[1] = {6'b001000, 5'd1, 5'd9, 16'hFFFF};
        bw[2] = {6'b001001, 5'd2, 5'd10, 16'h7FFF};
        bres[0] = 32'd11;
        bres[1] = 32'h0000_00FF;
        bres[2] = 32'h0000_8004;
        bdst[0] = 5'd8;
        bdst[1] = 5'd9;
        bdst[2] = 5'd10;
        tprev = 0;
        a_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            int n = 0;
            while (!a_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("b2b_ready_timeout", {31'b0, a_ready}, 32'd1);
            a_instr = bw[k];
            @(posedge clk);
            #1;
            t = cyc;
            e.wa = bdst[k];
            e.wd = bres[k];
            e.we = 1'b1;
            e.cy = t + 3;
            qa.push_back(e);
            if (k > 0) chk("b2b_accept_gap", 32'(t - tprev), 32'd4);
            tprev = t;
            @(negedge clk);
        end
        a_valid = 1'b0;
        repeat (5) @(negedge clk);

        // ALU_LAT=3: abort mid-EXEC, then a clean instruction.
        send_b({6'b001000, 5'd4, 5'd5, 16'hFFFD}, t);
        @(negedge clk);
        chk("b_exec_busy", {31'b0, b_busy}, 32'd1);
        #2;
        b_reset = 1'b1;
        #1;
        chk("b_abort_ready", {31'b0, b_ready}, 32'd1);
        chk("b_abort_busy", {31'b0, b_busy}, 32'd0);
        chk("b_abort_op", {26'b0, b_op}, 32'd0);
        chk("b_abort_reg2", b_r2, 32'd0);
        chk("b_abort_we", {31'b0, b_we}, 32'd0);
        @(negedge clk);
        b_reset = 1'b0;
        @(negedge clk);
        send_b({6'b001000, 5'd4, 5'd5, 16'hFFFD}, t);
        e.wa = 5'd5;
        e.wd = 32'd7;
        e.we = 1'b1;
        e.cy = t + 5;
        qb.push_back(e);
        repeat (8) @(negedge clk);

        chk("a_sb_drained", 32'(qa.size()), 32'd0);
        chk("b_sb_drained", 32'(qb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
